// File: rtl/dmem_pkg.sv
// Shared types and helpers for the multi-cycle data-memory responder.
package dmem_pkg;

  localparam int DEF_DEPTH = 64;
  localparam int DEF_LAT   = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Word index of a byte address; upper bits drop out so addresses wrap.
  function automatic logic [31:0] word_index(input logic [31:0] addr, input int aw);
    return (addr >> 2) & ((32'd1 << aw) - 32'd1);
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store port between the pipeline MEM stage (master) and the responder (slave).
interface dmem_responder_if;
  // A request transfers on a rising edge where req_valid and req_ready are both
  // high; the requester holds its request until then. resp_valid is a single-cycle
  // pulse with no back-pressure, and resp_rdata/resp_err are meaningful only with it.
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_array.sv
// Word storage: synchronous write, registered read, contents not reset.
module dmem_array #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder for the MEM stage.
// Define DMEM_WBUF_EN to add a one-entry posted write buffer with load forwarding.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int LAT   = DEF_LAT
) (
  input  logic            clk,
  input  logic            reset,
  dmem_responder_if.slave bus,
  output logic            busy,
  output logic [1:0]      dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] LAT_M1 = 4'(LAT - 1);
  localparam logic [3:0] LAT_M2 = (LAT >= 2) ? 4'(LAT - 2) : 4'd0;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          write_q, write_d, mis_q, mis_d;
  logic          rsel_q, rsel_d, err_q, err_d;
  logic [31:0]   fwd_q, fwd_d;

  logic          acc, req_mis, buf_acc, fwd_hit;
  logic [AW-1:0] req_idx;
  logic          cm_en, cm_write, cm_mis;
  logic [AW-1:0] cm_idx;
  logic [31:0]   fwd_src;
  logic          arr_we;
  logic [AW-1:0] arr_waddr;
  logic [31:0]   arr_wdata, arr_rdata;

  assign req_idx = AW'(word_index(bus.req_addr, AW));
  assign req_mis = |bus.req_addr[1:0];
  assign acc     = bus.req_valid && bus.req_ready;

  // The commit edge is where the array is touched: the accepting edge when LAT=1,
  // otherwise the WAIT edge on which the counter has reached zero.
  always_comb begin
    if (LAT == 1) begin
      cm_en    = acc && !buf_acc;
      cm_write = bus.req_write;
      cm_mis   = req_mis;
      cm_idx   = req_idx;
    end else begin
      cm_en    = (state_q == ST_WAIT) && (cnt_q == 4'd0);
      cm_write = write_q;
      cm_mis   = mis_q;
      cm_idx   = addr_q;
    end
  end

`ifdef DMEM_WBUF_EN
  logic          wb_valid_q, wb_valid_d, wb_drain;
  logic [AW-1:0] wb_idx_q, wb_idx_d;
  logic [31:0]   wb_data_q, wb_data_d;
  logic [3:0]    wb_cnt_q, wb_cnt_d;

  assign buf_acc       = acc && bus.req_write && !req_mis;
  assign wb_drain      = wb_valid_q && (wb_cnt_q == 4'd0);
  assign fwd_hit       = wb_valid_q && (wb_idx_q == cm_idx);
  assign fwd_src       = wb_data_q;
  assign bus.req_ready = (state_q != ST_WAIT) && !(wb_valid_q && bus.req_write);
  assign busy          = (state_q != ST_IDLE) || wb_valid_q;
  assign arr_we        = wb_drain;
  assign arr_waddr     = wb_idx_q;
  assign arr_wdata     = wb_data_q;

  always_comb begin
    wb_valid_d = wb_valid_q;
    wb_idx_d   = wb_idx_q;
    wb_data_d  = wb_data_q;
    wb_cnt_d   = wb_cnt_q;
    if (wb_drain) wb_valid_d = 1'b0;
    else if (wb_valid_q) wb_cnt_d = wb_cnt_q - 4'd1;
    if (buf_acc) begin
      wb_valid_d = 1'b1;
      wb_idx_d   = req_idx;
      wb_data_d  = bus.req_wdata;
      wb_cnt_d   = LAT_M1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_valid_q <= 1'b0;
      wb_idx_q   <= '0;
      wb_data_q  <= '0;
      wb_cnt_q   <= '0;
    end else begin
      wb_valid_q <= wb_valid_d;
      wb_idx_q   <= wb_idx_d;
      wb_data_q  <= wb_data_d;
      wb_cnt_q   <= wb_cnt_d;
    end
  end
`else
  logic [31:0] wdata_q, wdata_d;

  assign wdata_d       = acc ? bus.req_wdata : wdata_q;
  assign buf_acc       = 1'b0;
  assign fwd_hit       = 1'b0;
  assign fwd_src       = '0;
  assign bus.req_ready = (state_q != ST_WAIT);
  assign busy          = (state_q != ST_IDLE);
  assign arr_we        = cm_en && cm_write && !cm_mis;
  assign arr_waddr     = cm_idx;
  assign arr_wdata     = (LAT == 1) ? bus.req_wdata : wdata_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) wdata_q <= '0;
    else       wdata_q <= wdata_d;
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    write_d = write_q;
    mis_d   = mis_q;
    rsel_d  = 1'b0;
    err_d   = 1'b0;
    fwd_d   = '0;
    case (state_q)
      ST_IDLE, ST_RESP: begin
        state_d = ST_IDLE;
        if (acc) begin
          addr_d  = req_idx;
          write_d = bus.req_write;
          mis_d   = req_mis;
          if (buf_acc || LAT == 1) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = LAT_M2;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = ST_IDLE;
    endcase
    // Response fields are only ever set on the edge that enters RESP with a commit.
    if (cm_en) begin
      err_d  = cm_mis;
      rsel_d = !cm_write && !cm_mis && !fwd_hit;
      if (!cm_write && !cm_mis && fwd_hit) fwd_d = fwd_src;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      mis_q   <= 1'b0;
      rsel_q  <= 1'b0;
      err_q   <= 1'b0;
      fwd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      mis_q   <= mis_d;
      rsel_q  <= rsel_d;
      err_q   <= err_d;
      fwd_q   <= fwd_d;
    end
  end

  dmem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
    .clk   (clk),
    .we    (arr_we),
    .waddr (arr_waddr),
    .wdata (arr_wdata),
    .raddr (cm_idx),
    .rdata (arr_rdata)
  );

  assign bus.resp_valid = (state_q == ST_RESP);
  assign bus.resp_err   = err_q;
  assign bus.resp_rdata = (rsel_q ? arr_rdata : 32'd0) | fwd_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (DEPTH=64, LAT=2).
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int DEPTH = 64;
  localparam int LAT   = 2;
`ifdef DMEM_WBUF_EN
  localparam int ST_LAT = 1;
`else
  localparam int ST_LAT = LAT;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       busy;
  logic [1:0] dbg_state;
  int         passed = 0;
  int         total  = 0;

  dmem_responder_if bus();

  dmem_responder #(.DEPTH(DEPTH), .LAT(LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d,
                      output logic ok);
    int n;
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
    #1;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 20) begin
      if (bus.req_ready) ok = 1'b1;
      step();
      n++;
    end
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_resp(output int lat, output logic [31:0] rd, output logic er);
    lat = 1;
    while (!bus.resp_valid && lat < 20) begin
      step();
      lat++;
    end
    if (!bus.resp_valid) lat = -1;
    rd = bus.resp_rdata;
    er = bus.resp_err;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    repeat (3) step();
    total++; if (bus.req_ready !== 1'b1) $display("FAIL rst_ready: got %b exp 1", bus.req_ready); else passed++;
    total++; if (bus.resp_valid !== 1'b0) $display("FAIL rst_valid: got %b exp 0", bus.resp_valid); else passed++;
    total++; if (bus.resp_rdata !== 32'h0) $display("FAIL rst_rdata: got %h exp 0", bus.resp_rdata); else passed++;
    total++; if (bus.resp_err !== 1'b0) $display("FAIL rst_err: got %b exp 0", bus.resp_err); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b exp 0", busy); else passed++;
    reset = 1'b0;
    step();
    total++; if (dbg_state !== ST_IDLE) $display("FAIL rst_state: got %0d exp 0", dbg_state); else passed++;
    total++; if (bus.req_ready !== 1'b1) $display("FAIL post_rst_ready: got %b exp 1", bus.req_ready); else passed++;
  endtask

  task automatic test_store_load();
    logic ok, er; int lat; logic [31:0] rd;
    send(1'b1, 32'h10, 32'hDEADBEEF, ok);
    total++; if (ok !== 1'b1) $display("FAIL st_accept: got %b exp 1", ok); else passed++;
    wait_resp(lat, rd, er);
    total++; if (lat != ST_LAT) $display("FAIL st_lat: got %0d exp %0d", lat, ST_LAT); else passed++;
    total++; if (er !== 1'b0) $display("FAIL st_err: got %b exp 0", er); else passed++;
    total++; if (rd !== 32'h0) $display("FAIL st_rdata: got %h exp 0", rd); else passed++;
    send(1'b0, 32'h10, 32'h0, ok);
    wait_resp(lat, rd, er);
    total++; if (lat != LAT) $display("FAIL ld_lat: got %0d exp %0d", lat, LAT); else passed++;
    total++; if (rd !== 32'hDEADBEEF) $display("FAIL ld_rdata: got %h exp deadbeef", rd); else passed++;
    total++; if (er !== 1'b0) $display("FAIL ld_err: got %b exp 0", er); else passed++;
  endtask

  task automatic test_misaligned();
    logic ok, er; int lat; logic [31:0] rd;
    send(1'b0, 32'h12, 32'h0, ok);
    total++; if (busy !== 1'b1) $display("FAIL mis_busy: got %b exp 1", busy); else passed++;
    total++; if (dbg_state !== ST_WAIT) $display("FAIL mis_state: got %0d exp 1", dbg_state); else passed++;
    wait_resp(lat, rd, er);
    total++; if (lat != LAT) $display("FAIL mis_lat: got %0d exp %0d", lat, LAT); else passed++;
    total++; if (er !== 1'b1) $display("FAIL mis_err: got %b exp 1", er); else passed++;
    total++; if (rd !== 32'h0) $display("FAIL mis_rdata: got %h exp 0", rd); else passed++;
    send(1'b0, 32'h10, 32'h0, ok);
    wait_resp(lat, rd, er);
    total++; if (rd !== 32'hDEADBEEF) $display("FAIL mis_unchanged: got %h exp deadbeef", rd); else passed++;
  endtask

  task automatic test_back_to_back();
    logic ok, er; int lat; logic [31:0] rd;
    send(1'b1, 32'h0, 32'h000000A0, ok);
    wait_resp(lat, rd, er);
    send(1'b1, 32'h4, 32'h000000A4, ok);
    wait_resp(lat, rd, er);
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 32'h0;
    #1;
    total++; if (bus.req_ready !== 1'b1) $display("FAIL b2b_ready_first: got %b exp 1", bus.req_ready); else passed++;
    step();
    bus.req_addr = 32'h4;
    #1;
    total++; if (bus.req_ready !== 1'b0) $display("FAIL b2b_ready_wait: got %b exp 0", bus.req_ready); else passed++;
    step();
    total++; if (bus.resp_valid !== 1'b1) $display("FAIL b2b_valid1: got %b exp 1", bus.resp_valid); else passed++;
    total++; if (bus.resp_rdata !== 32'hA0) $display("FAIL b2b_rdata1: got %h exp a0", bus.resp_rdata); else passed++;
    total++; if (bus.req_ready !== 1'b1) $display("FAIL b2b_ready_resp: got %b exp 1", bus.req_ready); else passed++;
    step();
    total++; if (bus.resp_valid !== 1'b0) $display("FAIL b2b_gap: got %b exp 0", bus.resp_valid); else passed++;
    total++; if (bus.req_ready !== 1'b0) $display("FAIL b2b_ready_wait2: got %b exp 0", bus.req_ready); else passed++;
    bus.req_valid = 1'b0;
    step();
    total++; if (bus.resp_valid !== 1'b1) $display("FAIL b2b_valid2: got %b exp 1", bus.resp_valid); else passed++;
    total++; if (bus.resp_rdata !== 32'hA4) $display("FAIL b2b_rdata2: got %h exp a4", bus.resp_rdata); else passed++;
    step();
  endtask

  task automatic test_wrap();
    logic ok, er; int lat; logic [31:0] rd;
    send(1'b1, 32'h100, 32'h11111111, ok);
    wait_resp(lat, rd, er);
    send(1'b0, 32'h0, 32'h0, ok);
    wait_resp(lat, rd, er);
    total++; if (rd !== 32'h11111111) $display("FAIL wrap_rdata: got %h exp 11111111", rd); else passed++;
    total++; if (er !== 1'b0) $display("FAIL wrap_err: got %b exp 0", er); else passed++;
  endtask

  task automatic test_reset_mid();
    logic ok, er, saw; int lat; logic [31:0] rd;
    send(1'b1, 32'h20, 32'h12345678, ok);
    wait_resp(lat, rd, er);
    repeat (3) step();
    send(1'b1, 32'h20, 32'h5A5A5A5A, ok);
    reset = 1'b1;
    #1;
    total++; if (bus.req_ready !== 1'b1) $display("FAIL mid_ready: got %b exp 1", bus.req_ready); else passed++;
    total++; if (bus.resp_valid !== 1'b0) $display("FAIL mid_valid: got %b exp 0", bus.resp_valid); else passed++;
    total++; if (bus.resp_rdata !== 32'h0) $display("FAIL mid_rdata: got %h exp 0", bus.resp_rdata); else passed++;
    total++; if (bus.resp_err !== 1'b0) $display("FAIL mid_err: got %b exp 0", bus.resp_err); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL mid_busy: got %b exp 0", busy); else passed++;
    step();
    step();
    reset = 1'b0;
    saw = 1'b0;
    repeat (6) begin
      step();
      if (bus.resp_valid) saw = 1'b1;
    end
    total++; if (saw !== 1'b0) $display("FAIL mid_no_resp: got %b exp 0", saw); else passed++;
    send(1'b0, 32'h20, 32'h0, ok);
    wait_resp(lat, rd, er);
    total++; if (rd !== 32'h12345678) $display("FAIL mid_prior: got %h exp 12345678", rd); else passed++;
    total++; if (lat != LAT) $display("FAIL mid_lat: got %0d exp %0d", lat, LAT); else passed++;
  endtask

`ifdef DMEM_WBUF_EN
  task automatic test_wbuf();
    logic ok, er; int lat; logic [31:0] rd;
    repeat (2) step();
    send(1'b1, 32'h30, 32'hCAFEF00D, ok);
    wait_resp(lat, rd, er);
    total++; if (lat != 1) $display("FAIL wb_ack_lat: got %0d exp 1", lat); else passed++;
    send(1'b0, 32'h30, 32'h0, ok);
    wait_resp(lat, rd, er);
    total++; if (lat != LAT) $display("FAIL wb_fwd_lat: got %0d exp %0d", lat, LAT); else passed++;
    total++; if (rd !== 32'hCAFEF00D) $display("FAIL wb_fwd_rdata: got %h exp cafef00d", rd); else passed++;
    repeat (3) step();
    send(1'b1, 32'h34, 32'h0BADF00D, ok);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 32'h38; bus.req_wdata = 32'h600DF00D;
    #1;
    total++; if (bus.req_ready !== 1'b0) $display("FAIL wb_hold0: got %b exp 0", bus.req_ready); else passed++;
    step();
    total++; if (bus.resp_valid !== 1'b1) $display("FAIL wb_ack: got %b exp 1", bus.resp_valid); else passed++;
    total++; if (bus.req_ready !== 1'b0) $display("FAIL wb_hold1: got %b exp 0", bus.req_ready); else passed++;
    step();
    total++; if (bus.req_ready !== 1'b1) $display("FAIL wb_release: got %b exp 1", bus.req_ready); else passed++;
    step();
    bus.req_valid = 1'b0;
    wait_resp(lat, rd, er);
    total++; if (lat != 1) $display("FAIL wb_ack2_lat: got %0d exp 1", lat); else passed++;
    send(1'b0, 32'h34, 32'h0, ok);
    wait_resp(lat, rd, er);
    total++; if (rd !== 32'h0BADF00D) $display("FAIL wb_rd34: got %h exp 0badf00d", rd); else passed++;
    send(1'b0, 32'h38, 32'h0, ok);
    wait_resp(lat, rd, er);
    total++; if (rd !== 32'h600DF00D) $display("FAIL wb_rd38: got %h exp 600df00d", rd); else passed++;
  endtask
`endif

  // ---------------- sequence + report ----------------
  initial begin
    reset = 1'b1;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    test_reset();
    test_store_load();
    test_misaligned();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
`ifdef DMEM_WBUF_EN
    test_wbuf();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
